// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared widths and the MDU result-buffer entry layout for the GPR writeback front end.
package gpr_wb_arbiter_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int NREGS  = 1 << REG_W;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // {rd, data, pc}: 69 bits per buffered MDU result
    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] pc;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

    function automatic logic writes_reg(input logic [REG_W-1:0] rd);
        return rd != REG_ZERO;
    endfunction

endpackage

// File: rtl/gpr_wb_arbiter_if.sv
// Bundle of pipeline, MDU, decode-check and GPR write-port signals around the arbiter.
import gpr_wb_arbiter_pkg::*;

interface gpr_wb_arbiter_if;

    logic                 pipe_wr;
    logic [REG_W-1:0]     pipe_rd;
    logic [DATA_W-1:0]    pipe_data;
    logic                 pipe_jal;
    logic [DATA_W-1:0]    pipe_pc;
    logic                 pipe_stall;

    logic                 mdu_issue;
    logic [REG_W-1:0]     mdu_issue_rd;
    logic                 mdu_valid;
    logic                 mdu_ready;
    logic [REG_W-1:0]     mdu_rd;
    logic [DATA_W-1:0]    mdu_data;
    logic [DATA_W-1:0]    mdu_pc;

    logic [REG_W-1:0]     chk_r1;
    logic [REG_W-1:0]     chk_r2;
    logic                 busy1;
    logic                 busy2;

    logic                 WR;
    logic [REG_W-1:0]     mod_reg;
    logic [DATA_W-1:0]    in_data;
    logic                 jal;
    logic [DATA_W-1:0]    programCounter;

    modport slave (
        input  pipe_wr, pipe_rd, pipe_data, pipe_jal, pipe_pc,
        output pipe_stall,
        input  mdu_issue, mdu_issue_rd, mdu_valid, mdu_rd, mdu_data, mdu_pc,
        output mdu_ready,
        input  chk_r1, chk_r2,
        output busy1, busy2,
        output WR, mod_reg, in_data, jal, programCounter
    );

    modport master (
        output pipe_wr, pipe_rd, pipe_data, pipe_jal, pipe_pc,
        input  pipe_stall,
        output mdu_issue, mdu_issue_rd, mdu_valid, mdu_rd, mdu_data, mdu_pc,
        input  mdu_ready,
        output chk_r1, chk_r2,
        input  busy1, busy2,
        input  WR, mod_reg, in_data, jal, programCounter
    );

endinterface

// File: rtl/gpr_wb_arbiter_wb_fifo.sv
// Small FIFO holding completed MDU results until the GPR write port is free.
import gpr_wb_arbiter_pkg::*;

module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic      clk,
    input  logic      Reset,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    wb_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW:0]     count_reg;
    logic [AW:0]     count_next;

    // Storage has no reset: stale entries are unreachable once the count is cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_entry;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    // Head is read combinationally so the arbiter can decide and clear busy in the same cycle.
    assign head  = mem[rd_ptr_reg];
    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Arbitrates pipeline and buffered MDU results onto the single GPR write port and
// tracks registers with outstanding MDU writes so decode can stall on them.
import gpr_wb_arbiter_pkg::*;

module gpr_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic clk,
    input  logic Reset,
    gpr_wb_arbiter_if.slave bus
);

    wb_entry_t          push_entry;
    wb_entry_t          head;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               sel_pipe;

    logic               wr_reg,   wr_next;
    logic [REG_W-1:0]   rd_reg,   rd_next;
    logic [DATA_W-1:0]  data_reg, data_next;
    logic               jal_reg,  jal_next;
    logic [DATA_W-1:0]  pc_reg,   pc_next;

    logic [NREGS-1:1]   busy_reg;
    logic [NREGS-1:0]   busy_vec;

    assign push_entry = '{rd: bus.mdu_rd, data: bus.mdu_data, pc: bus.mdu_pc};
    assign push       = bus.mdu_valid && !full;

    wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk        (clk),
        .Reset      (Reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (full),
        .empty      (empty)
    );

    // A full buffer takes priority so the MDU can never deadlock behind a busy pipeline.
    assign sel_pipe = bus.pipe_wr && !full;
    assign pop      = !empty && !sel_pipe;

    always_comb begin
        wr_next   = 1'b0;
        rd_next   = REG_ZERO;
        data_next = '0;
        jal_next  = 1'b0;
        pc_next   = '0;
        if (sel_pipe) begin
            wr_next   = writes_reg(bus.pipe_rd);
            rd_next   = bus.pipe_rd;
            data_next = bus.pipe_data;
            jal_next  = bus.pipe_jal;
            pc_next   = bus.pipe_pc;
        end else if (pop) begin
            wr_next   = writes_reg(head.rd);
            rd_next   = head.rd;
            data_next = head.data;
            pc_next   = head.pc;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            wr_reg   <= 1'b0;
            rd_reg   <= REG_ZERO;
            data_reg <= '0;
            jal_reg  <= 1'b0;
            pc_reg   <= '0;
        end else begin
            wr_reg   <= wr_next;
            rd_reg   <= rd_next;
            data_reg <= data_next;
            jal_reg  <= jal_next;
            pc_reg   <= pc_next;
        end
    end

    // Issue for a register wins over the retirement of an older result to it.
    generate
        for (genvar gi = 1; gi < NREGS; gi++) begin : g_busy
            always_ff @(posedge clk or posedge Reset) begin
                if (Reset) begin
                    busy_reg[gi] <= 1'b0;
                end else if (bus.mdu_issue && (bus.mdu_issue_rd == REG_W'(gi))) begin
                    busy_reg[gi] <= 1'b1;
                end else if (pop && (head.rd == REG_W'(gi))) begin
                    busy_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign busy_vec = {busy_reg, 1'b0};

    assign bus.busy1          = busy_vec[bus.chk_r1];
    assign bus.busy2          = busy_vec[bus.chk_r2];
    assign bus.mdu_ready      = !full;
    assign bus.pipe_stall     = full && bus.pipe_wr;

    assign bus.WR             = wr_reg;
    assign bus.mod_reg        = rd_reg;
    assign bus.in_data        = data_reg;
    assign bus.jal            = jal_reg;
    assign bus.programCounter = pc_reg;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed and randomized checks of the GPR writeback arbiter against a queue-based model.
module tb_gpr_wb_arbiter;

    localparam int DEPTH = 2;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    logic clk = 1'b0;
    logic Reset;

    always #5 clk = ~clk;

    gpr_wb_arbiter_if bus ();

    gpr_wb_arbiter #(
        .DEPTH (DEPTH),
        .AW    (1)
    ) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];
    bit   busy_m [32];
    bit   was_stall;
    int   wr_pulses;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.pipe_wr      = 1'b0;
        bus.pipe_rd      = '0;
        bus.pipe_data    = '0;
        bus.pipe_jal     = 1'b0;
        bus.pipe_pc      = '0;
        bus.mdu_issue    = 1'b0;
        bus.mdu_issue_rd = '0;
        bus.mdu_valid    = 1'b0;
        bus.mdu_rd       = '0;
        bus.mdu_data     = '0;
        bus.mdu_pc       = '0;
        bus.chk_r1       = '0;
        bus.chk_r2       = '0;
    endtask

    task automatic model_clear();
        q.delete();
        for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
    endtask

    // One clock: check combinational outputs, advance the model, check the registered write.
    task automatic cycle();
        bit          full;
        bit          any;
        bit          exp_wr;
        ent_t        h;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic [31:0] e_pc;
        bit          e_jal;
        #1;
        full = (q.size() == DEPTH);
        chk("mdu_ready", bus.mdu_ready, !full);
        chk("pipe_stall", bus.pipe_stall, full && bus.pipe_wr);
        chk("busy1", bus.busy1, busy_m[bus.chk_r1]);
        chk("busy2", bus.busy2, busy_m[bus.chk_r2]);
        was_stall = full && bus.pipe_wr;
        any = 0; e_rd = '0; e_data = '0; e_pc = '0; e_jal = 0;
        if (bus.pipe_wr && !full) begin
            any = 1; e_rd = bus.pipe_rd; e_data = bus.pipe_data;
            e_pc = bus.pipe_pc; e_jal = bus.pipe_jal;
        end else if (q.size() > 0) begin
            h = q.pop_front();
            any = 1; e_rd = h.rd; e_data = h.data; e_pc = h.pc; e_jal = 0;
            busy_m[h.rd] = 1'b0;
        end
        if (bus.mdu_issue) busy_m[bus.mdu_issue_rd] = 1'b1;
        busy_m[0] = 1'b0;
        if (bus.mdu_valid && !full) q.push_back('{bus.mdu_rd, bus.mdu_data, bus.mdu_pc});
        exp_wr = any && (e_rd != 5'd0);
        @(posedge clk);
        #1;
        chk("WR", bus.WR, exp_wr);
        if (bus.WR === 1'b1) wr_pulses++;
        if (exp_wr) begin
            chk("mod_reg", bus.mod_reg, e_rd);
            chk("in_data", bus.in_data, e_data);
            chk("jal", bus.jal, e_jal);
            chk("programCounter", bus.programCounter, e_pc);
        end
    endtask

    initial begin
        Reset = 1'b1;
        idle();
        model_clear();
        #2;
        chk("rst_WR", bus.WR, 0);
        chk("rst_mod_reg", bus.mod_reg, 0);
        chk("rst_in_data", bus.in_data, 0);
        chk("rst_jal", bus.jal, 0);
        chk("rst_pc", bus.programCounter, 0);
        chk("rst_ready", bus.mdu_ready, 1);
        @(posedge clk); #1;
        Reset = 1'b0;

        // Pipeline only, then a jal link to r31
        bus.pipe_wr = 1; bus.pipe_rd = 5'd8; bus.pipe_data = 32'h1234; bus.pipe_pc = 32'h3000;
        cycle();
        bus.pipe_jal = 1; bus.pipe_rd = 5'd31; bus.pipe_data = 32'h40; bus.pipe_pc = 32'h3004;
        cycle();
        chk("jal_r31", bus.jal, 1);
        idle();

        // MDU issue, result, drain
        bus.mdu_issue = 1; bus.mdu_issue_rd = 5'd9; bus.chk_r1 = 5'd9;
        cycle();
        idle(); bus.chk_r1 = 5'd9;
        cycle();
        chk("busy9_set", bus.busy1, 1);
        bus.mdu_valid = 1; bus.mdu_rd = 5'd9; bus.mdu_data = 32'hDEAD; bus.mdu_pc = 32'h2000;
        cycle();
        bus.mdu_valid = 0;
        cycle();
        cycle();
        chk("busy9_clr", bus.busy1, 0);

        // Fill buffer behind a busy pipeline, then force a stall
        wr_pulses = 0;
        idle();
        bus.pipe_wr = 1; bus.pipe_rd = 5'd1; bus.pipe_data = 32'h11; bus.pipe_pc = 32'h100;
        bus.mdu_valid = 1; bus.mdu_rd = 5'd2; bus.mdu_data = 32'h22; bus.mdu_pc = 32'h200;
        cycle();
        bus.pipe_rd = 5'd3; bus.pipe_data = 32'h33; bus.pipe_pc = 32'h104;
        bus.mdu_rd = 5'd4; bus.mdu_data = 32'h44; bus.mdu_pc = 32'h204;
        cycle();
        bus.mdu_valid = 0;
        wr_pulses = 0;
        bus.pipe_rd = 5'd6; bus.pipe_data = 32'h66; bus.pipe_pc = 32'h108;
        #1;
        chk("full_ready", bus.mdu_ready, 0);
        chk("full_stall", bus.pipe_stall, 1);
        cycle();
        cycle();
        idle();
        cycle();
        cycle();
        chk("wr_pulses", wr_pulses, 3);

        // Writes to $0 from both sources are suppressed; the MDU entry still pops
        bus.pipe_wr = 1; bus.pipe_rd = 5'd0; bus.pipe_data = 32'hBAD0;
        bus.mdu_valid = 1; bus.mdu_rd = 5'd0; bus.mdu_data = 32'hBAD1;
        bus.mdu_issue = 1; bus.mdu_issue_rd = 5'd0;
        cycle();
        idle();
        cycle();
        cycle();
        chk("zero_ready", bus.mdu_ready, 1);

        // Same-cycle set and clear on r5
        bus.mdu_issue = 1; bus.mdu_issue_rd = 5'd5;
        bus.mdu_valid = 1; bus.mdu_rd = 5'd5; bus.mdu_data = 32'h55; bus.mdu_pc = 32'h500;
        cycle();
        idle();
        bus.mdu_issue = 1; bus.mdu_issue_rd = 5'd5; bus.chk_r1 = 5'd5;
        cycle();
        idle(); bus.chk_r1 = 5'd5;
        cycle();
        chk("busy5_kept", bus.busy1, 1);

        // Reset mid-stream with two buffered results
        idle();
        bus.pipe_wr = 1; bus.pipe_rd = 5'd3; bus.pipe_data = 32'h3; bus.pipe_pc = 32'h600;
        bus.mdu_issue = 1; bus.mdu_issue_rd = 5'd12; bus.chk_r1 = 5'd12; bus.chk_r2 = 5'd5;
        bus.mdu_valid = 1; bus.mdu_rd = 5'd12; bus.mdu_data = 32'hC; bus.mdu_pc = 32'h700;
        cycle();
        bus.mdu_rd = 5'd13; bus.mdu_issue_rd = 5'd13;
        cycle();
        #2;
        Reset = 1'b1;
        #1;
        chk("mid_rst_WR", bus.WR, 0);
        chk("mid_rst_busy1", bus.busy1, 0);
        chk("mid_rst_busy2", bus.busy2, 0);
        chk("mid_rst_ready", bus.mdu_ready, 1);
        model_clear();
        idle();
        @(posedge clk); #1;
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        // Random traffic; a stalled pipeline request is held unchanged
        was_stall = 0;
        for (int n = 0; n < 400; n++) begin
            if (!was_stall) begin
                bus.pipe_wr   = ($urandom_range(0, 99) < 55);
                bus.pipe_rd   = 5'($urandom_range(0, 7));
                bus.pipe_data = $urandom;
                bus.pipe_jal  = ($urandom_range(0, 3) == 0);
                bus.pipe_pc   = $urandom;
            end
            bus.mdu_issue    = ($urandom_range(0, 99) < 30);
            bus.mdu_issue_rd = 5'($urandom_range(0, 7));
            bus.mdu_valid    = ($urandom_range(0, 99) < 45);
            bus.mdu_rd       = 5'($urandom_range(0, 7));
            bus.mdu_data     = $urandom;
            bus.mdu_pc       = $urandom;
            bus.chk_r1       = 5'($urandom_range(0, 7));
            bus.chk_r2       = 5'($urandom_range(0, 31));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Writer-side front end for the 32x32 GPR: merges pipeline results and results from a long-latency unit (MDU: mul/div) onto the single GPR write port (WR, mod_reg, in_data, jal, programCounter).
- Buffers MDU results in a small FIFO and keeps a per-register busy scoreboard so decode can stall on pending MDU destinations.
- Sits between the WB stage / MDU and the GPR.

Parameters:
- DEPTH, 2, MDU result FIFO entries (power of 2, >=2)
- AW, 1, FIFO pointer width, log2(DEPTH)

Ports:
- clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- pipe_wr  in  1  pipeline requests a GPR write this cycle
- pipe_rd  in  5  pipeline destination register
- pipe_data  in  32  pipeline write data
- pipe_jal  in  1  pipeline write is a jal link (GPR adds 4)
- pipe_pc  in  32  PC of pipeline instruction
- pipe_stall  out  1  pipeline must hold its request unchanged next cycle
- mdu_issue  in  1  MDU op issued this cycle
- mdu_issue_rd  in  5  destination of issued MDU op
- mdu_valid  in  1  MDU result available
- mdu_ready  out  1  FIFO can accept (= !full)
- mdu_rd  in  5  MDU result destination
- mdu_data  in  32  MDU result data
- mdu_pc  in  32  PC of MDU instruction
- chk_r1, chk_r2  in  5 each  decode source registers to check
- busy1, busy2  out  1 each  chk_rX has a pending MDU write
- WR  out  1  GPR write enable
- mod_reg  out  5  GPR write address
- in_data  out  32  GPR write data
- jal  out  1  GPR jal flag
- programCounter  out  32  PC for the GPR write trace

Behaviour:
- Reset (async, active-high): WR=0, mod_reg=0, in_data=0, jal=0, programCounter=0. FIFO is emptied and all busy bits cleared. A reset mid-operation drops buffered MDU results; the MDU is flushed externally by the same Reset.
- GPR-side outputs are registered: a write selected in cycle N appears on WR/mod_reg/in_data/jal/programCounter in cycle N+1, for exactly one cycle.
- A write to $0 is suppressed (WR=0 that cycle). This holds for both sources. A suppressed MDU entry is still popped.
- FIFO:
  - Push when mdu_valid && mdu_ready.
  - mdu_ready is combinational = !full.
  - Pointers wrap modulo DEPTH; a count register distinguishes full from empty.
  - Simultaneous push and pop when full is not allowed, since ready=0. When empty, a push is not popped the same cycle (no bypass).
- Selection, each cycle:
  - Full FIFO and pipe_wr: FIFO head wins, pipe_stall=1, and the pipeline request is not consumed.
  - Otherwise pipe_wr=1: the pipeline wins, pipe_stall=0, and the FIFO holds.
  - Otherwise FIFO non-empty: pop the head.
  - Otherwise WR=0 next cycle.
  - pipe_stall is combinational = full && pipe_wr.
- jal output equals pipe_jal for pipeline writes and is 0 for MDU writes. Data is passed unmodified; the +4 is applied in the GPR.
- Scoreboard (busy[31:1], busy[0] tied 0):
  - Set by mdu_issue at mdu_issue_rd.
  - Cleared when an MDU entry with that rd is popped.
  - Set and clear on the same rd in the same cycle: set wins.
  - busyX = busy[chk_rX], combinational, with no bypass of a same-cycle pop.
- The pipeline writing a register that is busy is a software/hazard-unit error. It is not detected; the write proceeds.

Decomposition:
- Shared package (cpu_defs): REG_W=5, DATA_W=32, REG_ZERO=5'd0.
- One natural sub-module: wb_fifo (param DEPTH, 69-bit entry {rd, data, pc}, push/pop/full/empty).
- Scoreboard and arbitration stay in the top module.

Test Plan:
- Reset mid-stream: FIFO holds 2 entries, assert Reset -> WR=0 immediately, busy1=busy2=0, mdu_ready=1, and no write is emitted after deassert.
- Pipeline only: pipe_wr=1, rd=8, data=32'h1234, jal=0, pc=32'h3000 -> next cycle WR=1, mod_reg=8, in_data=32'h1234, programCounter=32'h3000. With pipe_jal=1 and rd=31 -> jal=1.
- MDU drain: issue rd=9 -> busy(9)=1. mdu_valid with data 32'hDEAD while pipe idle -> next cycle WR=1, mod_reg=9, in_data=32'hDEAD, jal=0, and busy(9)=0 after that edge.
- Priority and full: fill FIFO with 2 MDU results while pipe_wr=1 -> mdu_ready=0. On the next pipe_wr, pipe_stall=1 and the FIFO head is written. Pipe write appears after pipe_stall drops, with no writes lost: 3 WR pulses total.
- Zero register: pipe_wr=1 with rd=0, and MDU result with rd=0 -> WR stays 0 for both. FIFO count decrements. busy1 for chk_r1=0 is always 0.
- Same-cycle set/clear: pop an MDU entry for rd=5 while mdu_issue with rd=5 -> busy(5) remains 1.
